// File: rtl/half_adder_seq_ctrl.sv
// Bit-serial WIDTH-bit adder controller that time-shares one external,
// combinational half adder. Each operand bit uses two half-adder passes:
// P1 adds a[i]+b[i], and P2 adds that partial sum to the running carry.
// Optional feature macro: SERIAL_ADD_OVF_EN adds the signed-overflow output ovf.
module half_adder_seq_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ha_a,
    output logic             ha_b,
    input  logic             ha_sum,
    input  logic             ha_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {StIdle, StP1, StP2, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               s1_q, s1_d;
    logic               c1_q, c1_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               cim_q, cim_d;
`endif

    localparam logic [CNT_W-1:0] IdxLast = CNT_W'(WIDTH - 1);
`ifdef SERIAL_ADD_OVF_EN
    localparam logic [CNT_W-1:0] IdxPenult = CNT_W'(WIDTH - 2);
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            s1_q    <= 1'b0;
            c1_q    <= 1'b0;
            idx_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            cim_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            s1_q    <= s1_d;
            c1_q    <= c1_d;
            idx_q   <= idx_d;
`ifdef SERIAL_ADD_OVF_EN
            cim_q   <= cim_d;
`endif
        end
    end

    // Next-state logic and half-adder operand steering.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        s1_d    = s1_q;
        c1_d    = c1_q;
        idx_d   = idx_q;
`ifdef SERIAL_ADD_OVF_EN
        cim_d   = cim_q;
`endif
        ha_a    = 1'b0;
        ha_b    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = StP1;
                end
            end
            StP1: begin
                ha_a    = a_q[idx_q];
                ha_b    = b_q[idx_q];
                s1_d    = ha_sum;
                c1_d    = ha_carry;
                state_d = StP2;
            end
            StP2: begin
                ha_a         = s1_q;
                ha_b         = carry_q;
                sum_d[idx_q] = ha_sum;
                // The two half-adder carries are mutually exclusive, so OR suffices.
                carry_d      = c1_q | ha_carry;
`ifdef SERIAL_ADD_OVF_EN
                if (idx_q == IdxPenult) begin
                    cim_d = c1_q | ha_carry;
                end
`endif
                if (idx_q == IdxLast) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + CNT_W'(1);
                    state_d = StP1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake and result outputs, all derived from registered state.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        sum_out   = sum_q;
        cout      = carry_q;
`ifdef SERIAL_ADD_OVF_EN
        // Signed overflow: carry into the MSB differs from carry out of it.
        ovf       = (state_q == StDone) & (cim_q ^ carry_q);
`endif
    end

endmodule

// File: tb/tb_half_adder_seq_ctrl.sv
// Self-checking bench for half_adder_seq_ctrl (WIDTH=8) with an external
// half adder modelled by continuous assigns. Set SERIAL_ADD_OVF_EN to also
// exercise the ovf output.
module tb_half_adder_seq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         ha_a;
    logic         ha_b;
    logic         ha_sum;
    logic         ha_carry;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum_out;
    logic         cout;
    logic         ovf_v;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
    assign ovf_v = ovf;
`else
    assign ovf_v = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // External half adder.
    assign ha_sum   = ha_a ^ ha_b;
    assign ha_carry = ha_a & ha_b;

    half_adder_seq_ctrl #(
        .WIDTH(W),
        .CNT_W(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .ha_a     (ha_a),
        .ha_b     (ha_b),
        .ha_sum   (ha_sum),
        .ha_carry (ha_carry),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum_out  (sum_out),
        .cout     (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ovf_of(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] s;
        s = a + b;
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    // Transaction-level model: busy from accept until the result is taken;
    // the result becomes visible 2*W edges after the accept edge.
    logic         m_busy;
    int           m_cnt;
    logic [W:0]   m_exp;
    logic         m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1;
                m_cnt  <= 0;
                m_exp  <= {1'b0, a_in} + {1'b0, b_in};
                m_ovf  <= ovf_of(a_in, b_in);
            end
        end else if (m_cnt >= 2 * W) begin
            if (out_ready) m_busy <= 1'b0;
        end else begin
            m_cnt <= m_cnt + 1;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", 32'(in_ready), 32'(!m_busy));
            chk("out_valid", 32'(out_valid), 32'(m_busy && m_cnt >= 2 * W));
            if (m_busy && m_cnt >= 2 * W) begin
                chk("sum_out", 32'(sum_out), 32'(m_exp[W-1:0]));
                chk("cout", 32'(cout), 32'(m_exp[W]));
`ifdef SERIAL_ADD_OVF_EN
                chk("ovf", 32'(ovf_v), 32'(m_ovf));
`endif
            end
        end
    end

    // One operation: offer, wait for result, optional fixed hold, then take.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         input bit rnd_bp, output logic [W-1:0] s, output logic c,
                         output logic o, output int lat);
        int  guard;
        bit  taken;
        guard = 0;
        while (!in_ready && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("idle_wait", 0, 1);
        in_valid  = 1'b1;
        a_in      = a;
        b_in      = b;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // Keep in_valid high with junk operands: must be ignored while busy.
        a_in = W'($urandom);
        b_in = W'($urandom);
        lat  = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) chk("result_timeout", 0, 1);
        s = sum_out;
        c = cout;
        o = ovf_v;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_sum", 32'(sum_out), 32'(s));
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_out_valid", 32'(out_valid), 1);
        end
        taken = 1'b0;
        guard = 0;
        while (!taken && guard < 64) begin
            out_ready = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            taken     = out_ready && out_valid;
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        if (!taken) chk("handshake", 0, 1);
    endtask

    initial begin
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           lat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;

        // T1: reset values.
        #12;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_sum_out", 32'(sum_out), 0);
        chk("rst_cout", 32'(cout), 0);
        chk("rst_ha_a", 32'(ha_a), 0);
        chk("rst_ha_b", 32'(ha_b), 0);
        chk("rst_ovf", 32'(ovf_v), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // T2: zero plus zero; result visible 2*W edges after the accept edge.
        do_op(8'h00, 8'h00, 0, 1'b0, s, c, o, lat);
        chk("t2_sum", 32'(s), 32'h00);
        chk("t2_cout", 32'(c), 0);
        chk("t2_latency", 32'(lat), 16);

        // T3: carry out of the MSB, no signed overflow.
        do_op(8'hFF, 8'h01, 0, 1'b0, s, c, o, lat);
        chk("t3_sum", 32'(s), 32'h00);
        chk("t3_cout", 32'(c), 1);
`ifdef SERIAL_ADD_OVF_EN
        chk("t3_ovf", 32'(o), 0);
`endif

        // T4: signed overflow without carry out.
        do_op(8'h7F, 8'h01, 0, 1'b0, s, c, o, lat);
        chk("t4_sum", 32'(s), 32'h80);
        chk("t4_cout", 32'(c), 0);
`ifdef SERIAL_ADD_OVF_EN
        chk("t4_ovf", 32'(o), 1);
`endif

        // T5: five cycles of backpressure in DONE.
        do_op(8'hA5, 8'h5A, 5, 1'b0, s, c, o, lat);
        chk("t5_sum", 32'(s), 32'hFF);
        chk("t5_cout", 32'(c), 0);

        // T6: reset during an operation abandons it.
        in_valid = 1'b1;
        a_in     = 8'h12;
        b_in     = 8'h34;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 0);
        chk("t6_rst_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (24) begin
            @(posedge clk); #1;
        end
        chk("t6_no_result", 32'(out_valid), 0);
        do_op(8'h03, 8'h05, 0, 1'b0, s, c, o, lat);
        chk("t6_sum", 32'(s), 32'h08);
        chk("t6_cout", 32'(c), 0);

        // Sampled operand grid with random backpressure.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op(W'(i * 17), W'(j * 17 + i), 0, 1'b1, s, c, o, lat);
            end
        end
        // Random operands with random backpressure.
        for (int k = 0; k < 200; k++) begin
            do_op(W'($urandom), W'($urandom), 0, 1'b1, s, c, o, lat);
        end

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
